rob_ctrl: RTL and testbench

- Reorder buffer between an in-order client and an out-of-order memory responder.
- Accepts client read requests in order and tags each with a free slot ID. Issues each request to memory with that ID.
- Captures memory responses, which arrive in any order and always without backpressure.
- Returns data to the client strictly in request order over a valid/ready handshake.
- Direct upstream neighbour of the memory responder: it produces mem_req_* and consumes mem_rsp_*.

---
 rtl/rob_pkg.sv | 26 ++
 rtl/rob_slot_array.sv | 69 ++++++
 rtl/rob_ctrl.sv | 142 ++++++++++++++
 tb/tb_rob_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: default widths and the
// per-slot bookkeeping record used by the slot array and the controller.
package rob_pkg;

  localparam int ROB_IDWIDTH = 4;
  localparam int ROB_AWIDTH  = 32;
  localparam int ROB_DWIDTH  = 32;

  // pend: slot allocated to an in-flight request
  // done: response data captured and waiting to retire
  typedef struct packed {
    logic pend;
    logic done;
  } slot_state_t;

  // A slot may capture a response only while allocated and still waiting.
  function automatic logic slot_accepts_rsp(slot_state_t s);
    return s.pend & ~s.done;
  endfunction

  // A slot may retire once its data has arrived.
  function automatic logic slot_can_retire(slot_state_t s);
    return s.pend & s.done;
  endfunction

endpackage

// File: rtl/rob_slot_array.sv
// Per-slot pend/done bits plus the response data RAM. Three write ports
// (allocate, response capture, retire clear) and asynchronous reads at the
// retire pointer and at the incoming response ID.
module rob_slot_array
  import rob_pkg::*;
#(
  parameter int IDWIDTH = ROB_IDWIDTH,
  parameter int DWIDTH  = ROB_DWIDTH
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               alloc_en_i,
  input  logic [IDWIDTH-1:0] alloc_id_i,
  input  logic               rsp_en_i,
  input  logic [IDWIDTH-1:0] rsp_id_i,
  input  logic [DWIDTH-1:0]  rsp_data_i,
  input  logic               ret_en_i,
  input  logic [IDWIDTH-1:0] ret_id_i,
  input  logic [IDWIDTH-1:0] rd_id_i,
  output slot_state_t        rd_state_o,
  output logic [DWIDTH-1:0]  rd_data_o,
  output slot_state_t        rsp_state_o
);

  localparam int DEPTH = 1 << IDWIDTH;

  slot_state_t         state_q [DEPTH];
  slot_state_t         state_d [DEPTH];
  logic [DWIDTH-1:0]   data_q  [DEPTH];

  // Next slot state: the three ports never target the same slot in one
  // cycle (alloc and retire of one slot need a full buffer, and a retiring
  // slot is already done so it cannot capture), so their order is free.
  always_comb begin
    state_d = state_q;
    if (alloc_en_i) begin
      state_d[alloc_id_i] = '{pend: 1'b1, done: 1'b0};
    end
    if (rsp_en_i) begin
      state_d[rsp_id_i].done = 1'b1;
    end
    if (ret_en_i) begin
      state_d[ret_id_i] = '{pend: 1'b0, done: 1'b0};
    end
  end

  // Slot bookkeeping register; reset frees every slot.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= '{pend: 1'b0, done: 1'b0};
      end
    end else begin
      state_q <= state_d;
    end
  end

  // Data RAM is deliberately not reset; it is only read once done is set.
  always_ff @(posedge clk) begin
    if (rsp_en_i) begin
      data_q[rsp_id_i] <= rsp_data_i;
    end
  end

  assign rd_state_o  = state_q[rd_id_i];
  assign rd_data_o   = data_q[rd_id_i];
  assign rsp_state_o = state_q[rsp_id_i];

endmodule

// File: rtl/rob_ctrl.sv
// Reorder buffer controller: tags in-order client reads with slot IDs,
// collects out-of-order memory responses and returns data in request order.
// Optional protocol checking is compiled in when ROB_CHECK_EN is defined;
// otherwise rob_err is tied low.
module rob_ctrl
  import rob_pkg::*;
#(
  parameter int IDWIDTH = ROB_IDWIDTH,
  parameter int AWIDTH  = ROB_AWIDTH,
  parameter int DWIDTH  = ROB_DWIDTH
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               in_req_val,
  output logic               in_req_rdy,
  input  logic [AWIDTH-1:0]  in_req_addr,
  output logic               mem_req_val,
  output logic [AWIDTH-1:0]  mem_req_addr,
  output logic [IDWIDTH-1:0] mem_req_ID,
  input  logic               mem_rsp_val,
  input  logic [IDWIDTH-1:0] mem_rsp_ID,
  input  logic [DWIDTH-1:0]  mem_rsp_data,
  output logic               out_rsp_val,
  input  logic               out_rsp_rdy,
  output logic [DWIDTH-1:0]  out_rsp_data,
  output logic               rob_err
);

  localparam int                 DEPTH    = 1 << IDWIDTH;
  localparam logic [IDWIDTH:0]   FULL_CNT = (IDWIDTH+1)'(DEPTH);

  logic [IDWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDWIDTH:0]   cnt_q, cnt_d;

  logic        accept;
  logic        retire;
  logic        rsp_ok;
  slot_state_t rd_state;
  slot_state_t rsp_state;

  // Full is judged on registered occupancy only, so a same-cycle retire
  // never opens the request port.
  assign in_req_rdy   = (cnt_q != FULL_CNT);
  assign accept       = in_req_val & in_req_rdy;
  assign mem_req_val  = accept;
  assign mem_req_addr = in_req_addr;
  assign mem_req_ID   = wr_ptr_q;

  assign rsp_ok      = mem_rsp_val & slot_accepts_rsp(rsp_state);
  assign out_rsp_val = slot_can_retire(rd_state);
  assign retire      = out_rsp_val & out_rsp_rdy;

  rob_slot_array #(
    .IDWIDTH (IDWIDTH),
    .DWIDTH  (DWIDTH)
  ) u_slots (
    .clk         (clk),
    .rst_        (rst_),
    .alloc_en_i  (accept),
    .alloc_id_i  (wr_ptr_q),
    .rsp_en_i    (rsp_ok),
    .rsp_id_i    (mem_rsp_ID),
    .rsp_data_i  (mem_rsp_data),
    .ret_en_i    (retire),
    .ret_id_i    (rd_ptr_q),
    .rd_id_i     (rd_ptr_q),
    .rd_state_o  (rd_state),
    .rd_data_o   (out_rsp_data),
    .rsp_state_o (rsp_state)
  );

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (retire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({accept, retire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef ROB_CHECK_EN
  logic              err_q;
  logic              hold_q;
  logic [AWIDTH-1:0] hold_addr_q;
  logic              rsp_bad;
  logic              addr_bad;

  // A response is bad when its slot is idle or already holds data; a
  // stalled request is bad when its address moves while still waiting.
  assign rsp_bad  = mem_rsp_val & ~rsp_ok;
  assign addr_bad = hold_q & in_req_val & (in_req_addr != hold_addr_q);

  // Sticky error flag plus the stalled-request tracker it relies on.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      err_q       <= 1'b0;
      hold_q      <= 1'b0;
      hold_addr_q <= '0;
    end else begin
      hold_q      <= in_req_val & ~in_req_rdy;
      hold_addr_q <= in_req_addr;
      if (rsp_bad || addr_bad) begin
        err_q <= 1'b1;
      end
      if (rsp_bad) begin
        $error("rob_ctrl: invalid response to slot ID %0d", mem_rsp_ID);
      end
      if (addr_bad) begin
        $error("rob_ctrl: request address changed while stalled, ID %0d", wr_ptr_q);
      end
    end
  end

  assign rob_err = err_q;
`else
  assign rob_err = 1'b0;
`endif

endmodule

// File: tb/tb_rob_ctrl.sv
// Self-checking bench for rob_ctrl: directed scenarios followed by random
// traffic, all compared against an in-order queue model of the buffer.
module tb_rob_ctrl;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_;
  logic        in_req_val;
  logic        in_req_rdy;
  logic [31:0] in_req_addr;
  logic        mem_req_val;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_ID;
  logic        mem_rsp_val;
  logic [3:0]  mem_rsp_ID;
  logic [31:0] mem_rsp_data;
  logic        out_rsp_val;
  logic        out_rsp_rdy;
  logic [31:0] out_rsp_data;
  logic        rob_err;

  int testsRun;
  int testsFailed;

  // Reference model: queue of issued IDs in request order plus per-ID flags.
  int          idQ[$];
  bit          pendM [DEPTH];
  bit          doneM [DEPTH];
  logic [31:0] dataM [DEPTH];
  int          nextId;
  bit          errM;
  bit          prevHold;
  logic [31:0] prevAddr;

  rob_ctrl dut (
    .clk          (clk),
    .rst_         (rst_),
    .in_req_val   (in_req_val),
    .in_req_rdy   (in_req_rdy),
    .in_req_addr  (in_req_addr),
    .mem_req_val  (mem_req_val),
    .mem_req_addr (mem_req_addr),
    .mem_req_ID   (mem_req_ID),
    .mem_rsp_val  (mem_rsp_val),
    .mem_rsp_ID   (mem_rsp_ID),
    .mem_rsp_data (mem_rsp_data),
    .out_rsp_val  (out_rsp_val),
    .out_rsp_rdy  (out_rsp_rdy),
    .out_rsp_data (out_rsp_data),
    .rob_err      (rob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    idQ.delete();
    for (int i = 0; i < DEPTH; i++) begin
      pendM[i] = 1'b0;
      doneM[i] = 1'b0;
    end
    nextId   = 0;
    errM     = 1'b0;
    prevHold = 1'b0;
    prevAddr = '0;
  endtask

  // Asynchronous reset asserted between edges; reset values must appear at once.
  task automatic resetDut();
    @(negedge clk);
    in_req_val  = 1'b0;
    mem_rsp_val = 1'b0;
    out_rsp_rdy = 1'b0;
    #3;
    rst_ = 1'b0;
    #1;
    checkOutput("rst_in_req_rdy", 32'(in_req_rdy), 32'd1);
    checkOutput("rst_mem_req_val", 32'(mem_req_val), 32'd0);
    checkOutput("rst_out_rsp_val", 32'(out_rsp_val), 32'd0);
    checkOutput("rst_mem_req_ID", 32'(mem_req_ID), 32'd0);
    checkOutput("rst_rob_err", 32'(rob_err), 32'd0);
    modelReset();
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  // One cycle: drive inputs, compare outputs with the model, then advance it.
  task automatic applyStimulus(input logic v, input logic [31:0] a,
                               input logic rv, input logic [3:0] rid,
                               input logic [31:0] rdat, input logic ordy);
    bit expRdy, expOut, acc, ret, rspOk;
    @(negedge clk);
    in_req_val   = v;
    in_req_addr  = a;
    mem_rsp_val  = rv;
    mem_rsp_ID   = rid;
    mem_rsp_data = rdat;
    out_rsp_rdy  = ordy;
    #1;
    expRdy = (idQ.size() < DEPTH);
    expOut = (idQ.size() > 0) && doneM[idQ[0]];
    checkOutput("in_req_rdy", 32'(in_req_rdy), 32'(expRdy));
    checkOutput("mem_req_val", 32'(mem_req_val), 32'(v && expRdy));
    if (v && expRdy) begin
      checkOutput("mem_req_ID", 32'(mem_req_ID), 32'(nextId));
      checkOutput("mem_req_addr", mem_req_addr, a);
    end
    checkOutput("out_rsp_val", 32'(out_rsp_val), 32'(expOut));
    if (expOut) begin
      checkOutput("out_rsp_data", out_rsp_data, dataM[idQ[0]]);
    end
    checkOutput("rob_err", 32'(rob_err), 32'(errM));
    @(posedge clk);
    acc   = v && expRdy;
    ret   = expOut && ordy;
    rspOk = rv && pendM[rid] && !doneM[rid];
`ifdef ROB_CHECK_EN
    if (rv && !rspOk) errM = 1'b1;
    if (prevHold && v && (a != prevAddr)) errM = 1'b1;
`endif
    prevHold = v && !expRdy;
    prevAddr = a;
    if (rspOk) begin
      doneM[rid] = 1'b1;
      dataM[rid] = rdat;
    end
    if (ret) begin
      pendM[idQ[0]] = 1'b0;
      doneM[idQ[0]] = 1'b0;
      void'(idQ.pop_front());
    end
    if (acc) begin
      idQ.push_back(nextId);
      pendM[nextId] = 1'b1;
      doneM[nextId] = 1'b0;
      nextId = (nextId + 1) % DEPTH;
    end
  endtask

  initial begin
    int cand[$];
    logic        v, rv, ordy;
    logic [31:0] a, rdat;
    logic [3:0]  rid;

    testsRun     = 0;
    testsFailed  = 0;
    rst_         = 1'b1;
    in_req_val   = 1'b0;
    in_req_addr  = '0;
    mem_rsp_val  = 1'b0;
    mem_rsp_ID   = '0;
    mem_rsp_data = '0;
    out_rsp_rdy  = 1'b0;
    modelReset();

    // In-order single request, data 0xA5 one cycle after capture.
    resetDut();
    applyStimulus(1, 32'h100, 0, 4'd0, 32'h0, 1);
    applyStimulus(0, 32'h0, 1, 4'd0, 32'hA5, 1);
    applyStimulus(0, 32'h0, 0, 4'd0, 32'h0, 1);
    checkOutput("single_empty_after", 32'(idQ.size()), 32'd0);
    applyStimulus(0, 32'h0, 0, 4'd0, 32'h0, 1);

    // Reversed responses delivered in order.
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h200 + 32'(i), 0, 4'd0, 32'h0, 1);
    applyStimulus(0, 32'h0, 1, 4'd2, 32'hC2, 1);
    applyStimulus(0, 32'h0, 1, 4'd1, 32'hC1, 1);
    applyStimulus(0, 32'h0, 1, 4'd0, 32'hC0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 0, 4'd0, 32'h0, 1);

    // Full, retire one, wrap back to ID 0.
    resetDut();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 32'h300 + 32'(i), 0, 4'd0, 32'h0, 0);
    applyStimulus(1, 32'h400, 1, 4'd0, 32'hD0, 0);
    applyStimulus(1, 32'h400, 0, 4'd0, 32'h0, 1);
    applyStimulus(1, 32'h400, 0, 4'd0, 32'h0, 0);
    applyStimulus(0, 32'h0, 0, 4'd0, 32'h0, 0);

    // Backpressure: slot 0 done, client stalls five cycles.
    resetDut();
    applyStimulus(1, 32'h500, 0, 4'd0, 32'h0, 0);
    applyStimulus(0, 32'h0, 1, 4'd0, 32'h5A5A, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 32'h0, 0, 4'd0, 32'h0, 0);
    applyStimulus(0, 32'h0, 0, 4'd0, 32'h0, 1);
    applyStimulus(0, 32'h0, 0, 4'd0, 32'h0, 1);

    // Spurious response while idle.
    resetDut();
    applyStimulus(0, 32'h0, 1, 4'd7, 32'hBAD, 1);
    applyStimulus(0, 32'h0, 0, 4'd0, 32'h0, 1);
    applyStimulus(0, 32'h0, 0, 4'd0, 32'h0, 1);

    // Reset with three pending, then a stale response to ID 1.
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h600 + 32'(i), 0, 4'd0, 32'h0, 0);
    resetDut();
    applyStimulus(0, 32'h0, 1, 4'd1, 32'hDEAD, 1);
    applyStimulus(0, 32'h0, 0, 4'd0, 32'h0, 1);
    applyStimulus(1, 32'h700, 0, 4'd0, 32'h0, 1);

    // Random traffic.
    resetDut();
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 9) < 6);
      if (prevHold && v && ($urandom_range(0, 19) != 0)) a = prevAddr;
      else a = $urandom;
      cand.delete();
      foreach (idQ[k]) if (!doneM[idQ[k]]) cand.push_back(idQ[k]);
      rv   = 1'b0;
      rid  = 4'($urandom_range(0, DEPTH - 1));
      rdat = $urandom;
      if (cand.size() > 0 && ($urandom_range(0, 1) == 1)) begin
        rv  = 1'b1;
        rid = 4'(cand[$urandom_range(0, cand.size() - 1)]);
      end else if ($urandom_range(0, 39) == 0) begin
        rv = 1'b1;
      end
      ordy = ($urandom_range(0, 9) < 7);
      applyStimulus(v, a, rv, rid, rdat, ordy);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
